// File: rtl/alu_seq_pkg.sv
// Shared definitions for the alu_seq sequencer: opcodes, FSM states,
// instruction field positions and opcode classification helpers.
package alu_seq_pkg;

  // Encoding is the one the external ALU decodes for opcodes 0-6.
  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SLL = 4'd5,
    OP_SRL = 4'd6,
    OP_LDI = 4'd7,
    OP_NOP = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 9;
  localparam int unsigned RS1_MSB = 8;
  localparam int unsigned RS1_LSB = 6;
  localparam int unsigned RS2_MSB = 5;
  localparam int unsigned RS2_LSB = 3;
  localparam int unsigned IMM_MSB = 7;
  localparam int unsigned IMM_LSB = 0;

  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_NOP;
  endfunction

  function automatic logic writes_rd(input logic [3:0] op);
    return op <= OP_LDI;
  endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational opcode classifier for the sequencer: which opcodes write
// back, touch the flags, bypass the ALU, or are illegal.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [3:0] op_i,
  output logic       writes_rd_o,
  output logic       updates_flags_o,
  output logic       illegal_o,
  output logic       use_imm_o
);

  always_comb begin
    // NOTE: every output gets a default before any condition so no latch is inferred.
    writes_rd_o     = 1'b0;
    updates_flags_o = 1'b0;
    illegal_o       = 1'b0;
    use_imm_o       = 1'b0;
    if (!is_legal(op_i)) begin
      illegal_o = 1'b1;
    end else begin
      writes_rd_o     = writes_rd(op_i);
      updates_flags_o = (op_i <= OP_SRL);
      use_imm_o       = (op_i == OP_LDI);
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Four-phase instruction sequencer (IDLE/READ/EXEC/WB) driving an external
// 8x8 register file and 8-bit ALU; keeps Z/C flags and a retired count.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int unsigned RETIRE_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                instr_valid_i,
  input  logic [15:0]         instr_i,
  output logic                instr_ready_o,
  output logic [2:0]          rs1_addr_o,
  output logic [2:0]          rs2_addr_o,
  input  logic [7:0]          rs1_data_i,
  input  logic [7:0]          rs2_data_i,
  output logic [3:0]          alu_op_o,
  output logic [7:0]          alu_a_o,
  output logic [7:0]          alu_b_o,
  input  logic [7:0]          alu_result_i,
  input  logic                alu_carry_i,
  output logic                rd_wren_o,
  output logic [2:0]          rd_addr_o,
  output logic [7:0]          rd_data_o,
  output logic                done_o,
  output logic                illegal_o,
  output logic                flag_z_o,
  output logic                flag_c_o,
  output logic [RETIRE_W-1:0] retired_o
);

  state_e                state_q;
  logic [INSTR_W-1:0]    instr_q;
  logic [7:0]            a_q, b_q, result_q;
  logic                  carry_q;
  logic                  flag_z_q, flag_c_q;
  logic [RETIRE_W-1:0]   retired_q;
  logic                  rd_wren_q, done_q, illegal_q;

  logic [3:0] op;
  logic [2:0] rd;
  logic [7:0] imm;
  logic       dec_writes_rd, dec_updates_flags, dec_illegal, dec_use_imm;

  assign op  = instr_q[OP_MSB:OP_LSB];
  assign rd  = instr_q[RD_MSB:RD_LSB];
  assign imm = instr_q[IMM_MSB:IMM_LSB];

  alu_seq_decode u_decode (
    .op_i            (op),
    .writes_rd_o     (dec_writes_rd),
    .updates_flags_o (dec_updates_flags),
    .illegal_o       (dec_illegal),
    .use_imm_o       (dec_use_imm)
  );

  // Done/write/illegal are registered on the EXEC->WB edge so they are
  // glitch-free and high for exactly the WB cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: async reset clears every register, which also aborts an in-flight
    // instruction before it can write, pulse done or count.
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      instr_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      flag_z_q  <= 1'b0;
      flag_c_q  <= 1'b0;
      retired_q <= '0;
      rd_wren_q <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      rd_wren_q <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (instr_valid_i) begin
            instr_q <= instr_i;
            state_q <= ST_READ;
          end
        end
        ST_READ: begin
          a_q     <= rs1_data_i;
          b_q     <= rs2_data_i;
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          result_q  <= dec_use_imm ? imm : alu_result_i;
          carry_q   <= alu_carry_i;
          rd_wren_q <= dec_writes_rd;
          done_q    <= 1'b1;
          illegal_q <= dec_illegal;
          state_q   <= ST_WB;
        end
        ST_WB: begin
          if (dec_updates_flags) begin
            flag_z_q <= (result_q == 8'h00);
            flag_c_q <= carry_q;
          end
          if (!dec_illegal) retired_q <= retired_q + RETIRE_W'(1);
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign instr_ready_o = (state_q == ST_IDLE);
  assign rs1_addr_o    = instr_q[RS1_MSB:RS1_LSB];
  assign rs2_addr_o    = instr_q[RS2_MSB:RS2_LSB];
  assign alu_op_o      = (state_q == ST_EXEC) ? op  : 4'h0;
  assign alu_a_o       = (state_q == ST_EXEC) ? a_q : 8'h00;
  assign alu_b_o       = (state_q == ST_EXEC) ? b_q : 8'h00;
  assign rd_wren_o     = rd_wren_q;
  assign rd_addr_o     = rd;
  assign rd_data_o     = result_q;
  assign done_o        = done_q;
  assign illegal_o     = illegal_q;
  assign flag_z_o      = flag_z_q;
  assign flag_c_o      = flag_c_q;
  assign retired_o     = retired_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: behavioural register file and ALU,
// plus an arithmetic reference model of architectural state.
module tb_alu_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [2:0]  rs1_addr, rs2_addr, rd_addr;
  logic [7:0]  rs1_data, rs2_data, alu_a, alu_b, alu_result, rd_data;
  logic [3:0]  alu_op;
  logic        alu_carry, rd_wren, done, illegal, flag_z, flag_c;
  logic [15:0] retired;

  logic        x4_ready, x4_wren, x4_done, x4_illegal, x4_z, x4_c;
  logic [2:0]  x4_rs1, x4_rs2, x4_rd;
  logic [3:0]  x4_op;
  logic [7:0]  x4_a, x4_b, x4_data;
  logic [3:0]  retired4;

  alu_seq_ctrl #(.RETIRE_W(16)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .instr_valid_i(instr_valid), .instr_i(instr),
    .instr_ready_o(instr_ready), .rs1_addr_o(rs1_addr), .rs2_addr_o(rs2_addr),
    .rs1_data_i(rs1_data), .rs2_data_i(rs2_data), .alu_op_o(alu_op),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_result_i(alu_result),
    .alu_carry_i(alu_carry), .rd_wren_o(rd_wren), .rd_addr_o(rd_addr),
    .rd_data_o(rd_data), .done_o(done), .illegal_o(illegal),
    .flag_z_o(flag_z), .flag_c_o(flag_c), .retired_o(retired)
  );

  // Narrow-counter instance sees the identical instruction stream.
  alu_seq_ctrl #(.RETIRE_W(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .instr_valid_i(instr_valid), .instr_i(instr),
    .instr_ready_o(x4_ready), .rs1_addr_o(x4_rs1), .rs2_addr_o(x4_rs2),
    .rs1_data_i(rs1_data), .rs2_data_i(rs2_data), .alu_op_o(x4_op),
    .alu_a_o(x4_a), .alu_b_o(x4_b), .alu_result_i(alu_result),
    .alu_carry_i(alu_carry), .rd_wren_o(x4_wren), .rd_addr_o(x4_rd),
    .rd_data_o(x4_data), .done_o(x4_done), .illegal_o(x4_illegal),
    .flag_z_o(x4_z), .flag_c_o(x4_c), .retired_o(retired4)
  );

  // Register file and ALU models
  logic [7:0] rf [8] = '{default: 8'h00};
  always @(posedge clk) if (rd_wren) rf[rd_addr] <= rd_data;
  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];

  logic [8:0] alu_full;
  always_comb begin
    alu_full = 9'h000;
    case (alu_op)
      4'd0: alu_full = {1'b0, alu_a} + {1'b0, alu_b};
      4'd1: alu_full = {1'b0, alu_a} - {1'b0, alu_b};
      4'd2: alu_full = {1'b0, alu_a & alu_b};
      4'd3: alu_full = {1'b0, alu_a | alu_b};
      4'd4: alu_full = {1'b0, alu_a ^ alu_b};
      4'd5: alu_full = {1'b0, alu_a << alu_b[2:0]};
      4'd6: alu_full = {1'b0, alu_a >> alu_b[2:0]};
      default: alu_full = 9'h000;
    endcase
  end
  assign alu_result = alu_full[7:0];
  assign alu_carry  = alu_full[8];

  // Reference architectural state
  int unsigned ref_rf [8] = '{default: 0};
  bit          ref_z = 1'b0, ref_c = 1'b0;
  int unsigned ref_cnt = 0;
  time         last_accept = 0;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mk(input int op, input int rd, input int s1, input int s2);
    return {4'(op), 3'(rd), 3'(s1), 3'(s2), 3'b000};
  endfunction

  function automatic logic [15:0] mk_ldi(input int rd, input int imm);
    return {4'd7, 3'(rd), 1'b0, 8'(imm)};
  endfunction

  task automatic check_arch(input string tag);
    check({tag, "_z"}, flag_z, ref_z);
    check({tag, "_c"}, flag_c, ref_c);
    check({tag, "_retired"}, retired, ref_cnt % 65536);
    check({tag, "_retired4"}, retired4, ref_cnt % 16);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_outputs_zero",
          {rs1_addr, rs2_addr, alu_op, alu_a, alu_b, rd_wren, rd_addr, rd_data,
           done, illegal, flag_z, flag_c}, 64'd0);
    check("rst_ready", instr_ready, 1'b1);
    check("rst_retired", retired, 0);
    check("rst_retired4", retired4, 0);
    ref_z = 1'b0; ref_c = 1'b0; ref_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issue one instruction (called at a negedge) and check it end to end.
  task automatic issue(input logic [15:0] ins, input bit hold_valid, input bit check_gap);
    int unsigned op, rd, s1, s2, a, b, res, full;
    bit cy, wr, upd, ill;
    logic [3:1] wren_seen, done_seen, ill_seen, ready_seen;
    int waitc;
    op = ins[15:12]; rd = ins[11:9]; s1 = ins[8:6]; s2 = ins[5:3];
    a = ref_rf[s1]; b = ref_rf[s2];
    res = 0; cy = 1'b0;
    case (op)
      0: begin full = a + b; res = full % 256; cy = (full > 255); end
      1: begin res = (a + 256 - b) % 256; cy = (a < b); end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = (a * (1 << (b % 8))) % 256;
      6: res = a / (1 << (b % 8));
      7: res = ins[7:0];
      default: res = 0;
    endcase
    wr = (op <= 7); upd = (op <= 6); ill = (op >= 9);

    instr = ins;
    instr_valid = 1'b1;
    waitc = 0;
    while (!instr_ready && waitc < 16) begin
      @(negedge clk);
      waitc++;
    end
    if (!instr_ready) begin
      check("accept_timeout", 1'b0, 1'b1);
      instr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (check_gap) check("accept_gap_ns", $time - last_accept, 40);
    last_accept = $time;
    #1;
    if (!hold_valid) instr_valid = 1'b0;

    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      wren_seen[c]  = rd_wren;
      done_seen[c]  = done;
      ill_seen[c]   = illegal;
      ready_seen[c] = instr_ready;
      if (c == 2 && upd) begin
        check("exec_alu_op", alu_op, op);
        check("exec_alu_a", alu_a, a);
        check("exec_alu_b", alu_b, b);
      end
      if (c == 3 && wr) begin
        check("wb_rd_addr", rd_addr, rd);
        check("wb_rd_data", rd_data, res);
      end
    end
    check("wren_timing", wren_seen, wr ? 3'b100 : 3'b000);
    check("done_timing", done_seen, 3'b100);
    check("illegal_timing", ill_seen, ill ? 3'b100 : 3'b000);
    check("ready_busy", ready_seen, 3'b000);

    if (wr) ref_rf[rd] = res;
    if (upd) begin ref_z = (res == 0); ref_c = cy; end
    if (!ill) ref_cnt++;

    @(negedge clk);
    check("post_wren_low", {rd_wren, done, illegal}, 3'b000);
    check("post_ready", instr_ready, 1'b1);
    check("rf_rd", rf[rd], ref_rf[rd]);
    check_arch("post");
  endtask

  initial begin
    logic [15:0] ins;
    logic [7:0]  rd_before;
    bit          saw_done;
    instr_valid = 1'b0;
    instr = 16'h0000;
    #2;
    do_reset();

    // LDI + ADD
    issue(mk_ldi(1, 8'h7F), 1'b0, 1'b0);
    issue(mk_ldi(2, 8'h01), 1'b0, 1'b0);
    issue(mk(0, 3, 1, 2), 1'b0, 1'b0);
    check("add_r3", rf[3], 8'h80);
    check("add_zc", {flag_z, flag_c}, 2'b00);
    check("add_retired", retired, 3);

    // SUB to zero, overflowing ADD
    issue(mk(1, 4, 1, 1), 1'b0, 1'b0);
    check("sub_r4", rf[4], 8'h00);
    check("sub_z", flag_z, 1'b1);
    issue(mk_ldi(5, 8'hFF), 1'b0, 1'b0);
    issue(mk_ldi(6, 8'h01), 1'b0, 1'b0);
    issue(mk(0, 7, 5, 6), 1'b0, 1'b0);
    check("ovf_r7", rf[7], 8'h00);
    check("ovf_zc", {flag_z, flag_c}, 2'b11);

    // Illegal opcode leaves flags and count alone
    issue(mk(12, 2, 1, 1), 1'b0, 1'b0);
    check("illegal_zc", {flag_z, flag_c}, 2'b11);
    check("illegal_retired", retired, 7);
    check("illegal_r2", rf[2], 8'h01);

    // Back-to-back with valid held high
    issue(mk(3, 1, 1, 2), 1'b1, 1'b0);
    issue(mk(4, 2, 1, 6), 1'b1, 1'b1);
    issue(mk(2, 3, 2, 1), 1'b1, 1'b1);
    issue(mk(0, 4, 4, 4), 1'b0, 1'b1);

    // Randomized traffic, mostly legal opcodes
    for (int i = 0; i < 60; i++) begin
      ins = 16'($urandom);
      if ($urandom_range(0, 5) != 0) ins[15:12] = 4'($urandom_range(0, 8));
      issue(ins, 1'($urandom_range(0, 1)) & (i != 59), 1'b0);
    end

    // Reset during EXEC of an ADD aborts it
    issue(mk_ldi(5, 8'h11), 1'b0, 1'b0);
    rd_before = rf[3];
    instr = mk(0, 3, 5, 5);
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    do_reset();
    saw_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      saw_done = saw_done | done | rd_wren;
    end
    check("abort_no_done", saw_done, 1'b0);
    check("abort_rf_kept", rf[3], rd_before);
    check_arch("abort");

    // Counter wrap on the 4-bit instance
    do_reset();
    for (int i = 0; i < 17; i++) issue(16'h8000, 1'b0, 1'b0);
    check("wrap_retired4", retired4, 4'd1);
    check("wrap_retired16", retired, 17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d expected=done", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Multi-cycle instruction sequencer for the 8-bit datapath: the 8×8 register file (two combinational read ports, one synchronous write port) and the combinational 8-bit ALU. It accepts one 16-bit instruction at a time over a valid/ready handshake. It reads operands from the register file, drives the ALU, and writes the result back. It also keeps Z/C status flags and a count of retired instructions. It sits between the instruction source (test sequencer or host FSM) and the register-file/ALU pair.

## Interface
- RETIRE_W, 16, width of retired-instruction counter
- clk_i  in  1  clock; all state updates on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- instr_valid_i  in  1  instruction offered
- instr_i  in  16  instruction: op[15:12], rd[11:9], rs1[8:6], rs2[5:3]; LDI immediate = [7:0]
- instr_ready_o  out  1  high only in IDLE
- rs1_addr_o, rs2_addr_o  out  3  register-file read addresses
- rs1_data_i, rs2_data_i  in  8  register-file read data, combinational from the addresses
- alu_op_o  out  4  ALU operation code
- alu_a_o, alu_b_o  out  8  ALU operands
- alu_result_i  in  8  ALU result
- alu_carry_i  in  1  ALU carry/borrow out
- rd_wren_o, rd_addr_o (3), rd_data_o (8)  out  register-file write port
- done_o  out  1  one-cycle pulse when an instruction completes, including illegal ones
- illegal_o  out  1  one-cycle pulse, coincident with done_o, for an illegal opcode
- flag_z_o, flag_c_o  out  1  status flags
- retired_o  out  RETIRE_W  count of completed legal instructions

## Operation
- **FSM:** IDLE → READ → EXEC → WB → IDLE. No other transitions except reset.
- **IDLE:** instr_ready_o = 1. On instr_valid_i & instr_ready_o, capture instr_i into the instruction register and go to READ.
- **READ:**
  - rs1_addr_o/rs2_addr_o come from the instruction register and hold stable through WB.
  - Latch rs1_data_i/rs2_data_i into operand registers A/B.
- **EXEC:**
  - alu_a_o = A, alu_b_o = B, alu_op_o = op.
  - Latch alu_result_i and alu_carry_i into the result register.
  - For LDI, latch imm[7:0] instead of the ALU result.
- **WB:**
  - For ADD, SUB, AND, OR, XOR, SLL, SRL and LDI: rd_wren_o = 1, rd_addr_o = rd, rd_data_o = result register.
  - done_o = 1.
  - retired_o increments by 1 for legal opcodes and wraps at 2^RETIRE_W.
- **Opcodes:**
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL: passed to the ALU unchanged.
  - 7 LDI: the ALU is bypassed.
  - 8 NOP: no write, but counted.
  - 9–15 illegal: no write, no flag update, not counted, illegal_o pulses in WB.
- **Flags:** update in WB for opcodes 0–6 only.
  - Z = (result == 0).
  - C = latched carry.
  - LDI and NOP leave both flags unchanged.
- **Operand/destination overlap:** rd equal to rs1 or rs2 is legal. Operands are read before the write, so the old value is used.
- **Outside active states:** alu_op_o/alu_a_o/alu_b_o are don't-care outside EXEC. The bench checks them only in EXEC.
- **Reset:**
  - All state, flags and the counter clear, and the FSM goes to IDLE.
  - All outputs are 0, except instr_ready_o = 1 after reset.
  - Reset asserted mid-instruction aborts it: no write, no done_o, no count.

## Timing
- Handshake accepted at edge T. READ during cycle T+1, EXEC during T+2, WB during T+3 (rd_wren_o, done_o high). Next acceptance is possible at edge T+4.
- Throughput is one instruction per 4 cycles. Latency from acceptance to write-enable is 3 cycles.
- The register-file write commits at the rising edge ending the WB cycle.
- Flag and counter updates are visible in the cycle after WB.
- instr_valid_i is ignored outside IDLE. The source holds the instruction until ready.
- rd_wren_o, done_o and illegal_o are never high for more than one cycle per instruction.

## Structure
- Shared package alu_seq_pkg:
  - op_e enum (4-bit opcodes above).
  - state_e enum (IDLE, READ, EXEC, WB).
  - Instruction field bit-position constants and is_legal/writes_rd helper functions.
- The ALU opcode encoding in the package is the one the ALU decodes.
- One natural sub-module: alu_seq_decode (combinational: op → writes_rd, updates_flags, illegal, use_imm).
- Register file and ALU stay outside; the controller only drives their ports.

## Test plan
- **Reset:** rst_ni low mid-stream → all outputs 0, instr_ready_o = 1, retired_o = 0.
- **LDI + ADD:** LDI r1,0x7F; LDI r2,0x01; ADD r3,r1,r2 → r3 = 0x80, Z = 0, C = 0, retired_o = 3. rd_wren_o is high exactly 3 cycles after each accept.
- **SUB to zero:** SUB r4,r1,r1 with r1 = 0x7F → r4 = 0x00, Z = 1. Overflowing ADD 0xFF + 0x01 → 0x00, Z = 1, C = 1.
- **Illegal opcode:** op = 0xC → illegal_o and done_o pulse in WB, rd_wren_o stays 0, flags and retired_o unchanged.
- **Back-to-back valids:** instr_valid_i held high with 4 instructions → accepts spaced exactly 4 cycles apart. instr_ready_o is low in READ/EXEC/WB.
- **Abort and wrap:** rst_ni asserted during EXEC of an ADD → no write, no done_o. Separately, RETIRE_W = 4, 17 NOPs → retired_o = 1.
